serial_adder_nbit: RTL and testbench
====================================

Name: serial_adder_nbit

Overview:
Multi-cycle, parametrised N-bit adder/subtractor that processes CHUNK bits per clock and passes the carry between chunks in a register. It is the next generation of the 1-bit full adder: generalised width, selectable add/subtract, signed overflow detection and a valid/ready handshake on both sides. It sits in the ALU for area-constrained datapaths where a full-width combinational carry chain is not wanted.

Parameters:
WIDTH, 16, operand and result width in bits; must be a multiple of CHUNK.
CHUNK, 4, bits added per clock cycle; CHUNK equal to WIDTH gives a single-cycle adder.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  operands and mode are valid.
in_ready  output  1  block can accept operands; high only in IDLE.
in0  input  WIDTH  operand A.
in1  input  WIDTH  operand B.
cin  input  1  carry in; ignored when sub=1.
sub  input  1  0 selects A+B+cin; 1 selects A-B.
out_valid  output  1  result is valid; high only in DONE.
out_ready  input  1  consumer accepts the result.
sum  output  WIDTH  result.
cout  output  1  carry out of the MSB; for subtraction 1 means no borrow.
overflow  output  1  two's-complement signed overflow.

Behaviour:
- States: IDLE, RUN, DONE. NCHUNK = WIDTH/CHUNK.
- Reset (asynchronous, any state, including mid-RUN): state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0, overflow=0, chunk index=0, carry register=0. Any partial result is discarded.
- IDLE: on in_valid&&in_ready, register A=in0, B=(sub ? ~in1 : in1), carry=(sub ? 1 : cin), index=0, then go to RUN. The operands are sampled only on this edge. in0, in1, cin and sub may change afterwards.
- RUN, each cycle: add bits [index*CHUNK +: CHUNK] of A and B with the carry register. Write the chunk result into sum at the same bit slice, update the carry register, then index++. Chunks are processed LSB first.
- On the last chunk (index==NCHUNK-1):
  - cout = final carry.
  - overflow = (A[MSB]==B[MSB]) && (sum[MSB]!=A[MSB]), using the inverted B when subtracting.
  - go to DONE.
- Latency: out_valid rises NCHUNK cycles after the acceptance edge. With the defaults this is 4 cycles.
- DONE: out_valid=1. sum, cout and overflow are held stable until out_valid&&out_ready. On that edge: go to IDLE, out_valid=0. The result registers keep their values.
- Throughput: one operation per NCHUNK+2 cycles. There is no acceptance in DONE, so in_ready=0 during RUN and DONE. in_valid asserted outside IDLE is ignored and nothing is queued.
- sum bits beyond the current chunk during RUN are don't-care to the consumer and are only specified when out_valid=1.
- Width rules: chunk adder is CHUNK+1 bits wide; no sign extension; the result wraps modulo 2^WIDTH.

Optional Feature:
SERIAL_ADDER_ZERO_FLAG_EN
- Defined: extra output port "zero" (output, 1 bit), set when the final sum==0.
  - It is computed as the AND of per-chunk zero results accumulated during RUN, with no full-width compare.
  - Valid with out_valid and held in DONE.
  - Reset value 0. Cleared at operand acceptance.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
WIDTH=16, CHUNK=4 unless noted.
1. Basic add: 0x1234+0x4321, cin=0, sub=0 -> sum=0x5555, cout=0, overflow=0; out_valid rises exactly 4 cycles after the accept edge; in_ready low from the accept edge until the handshake edge.
2. Wrap-around: 0xFFFF+0x0001, cin=0 -> sum=0x0000, cout=1, overflow=0; with SERIAL_ADDER_ZERO_FLAG_EN defined, zero=1. Also 0xFFFE+0x0000 with cin=1 -> 0xFFFF, cout=0.
3. Subtract: 0x0005-0x0007 (sub=1, cin=1 ignored) -> 0xFFFE, cout=0. Then 0x0007-0x0005 -> 0x0002, cout=1. Then 0x8000-0x0001 -> 0x7FFF, overflow=1.
4. Signed overflow: 0x7FFF+0x0001 -> 0x8000, overflow=1. 0x8000+0x8000 -> 0x0000, cout=1, overflow=1.
5. Backpressure: hold out_ready=0 for 5 cycles in DONE -> sum, cout and out_valid stay stable; in_ready=0; an in_valid pulse during RUN/DONE is ignored. The next result corresponds only to operands presented after the return to IDLE.
6. Reset mid-op: assert rst asynchronously during the 2nd RUN cycle -> in_ready=1, out_valid=0, sum=0 immediately. After release, the next operation (0x0001+0x0001) returns 0x0002 with no stale carry. Repeat test 1 with CHUNK=16 (latency 1) and CHUNK=1 (latency 16).

Source files
------------

// File: rtl/serial_adder_nbit.sv
// Multi-cycle N-bit add/subtract, CHUNK bits per clock, carry kept in a register between chunks.
// Latency: out_valid rises WIDTH/CHUNK cycles after the accept edge; one operation per NCHUNK+2 cycles.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready. Define SERIAL_ADDER_ZERO_FLAG_EN to add the zero output.
module serial_adder_nbit #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
`ifdef SERIAL_ADDER_ZERO_FLAG_EN
    ,
    output logic             zero
`endif
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int MSB    = WIDTH - 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(NCHUNK - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry;
    logic [IDXW-1:0]  idx;

    logic [CHUNK-1:0] a_ch;
    logic [CHUNK-1:0] b_ch;
    logic [CHUNK:0]   ch_sum;
    logic [WIDTH-1:0] sum_nxt;
    logic             last;
    logic             ovf_nxt;

    // Constant-slice muxes keep the part-selects static for any CHUNK/WIDTH pair.
    always_comb begin
        a_ch    = '0;
        b_ch    = '0;
        sum_nxt = sum;
        for (int i = 0; i < NCHUNK; i++) begin
            if (idx == IDXW'(i)) begin
                a_ch = a_q[i*CHUNK +: CHUNK];
                b_ch = b_q[i*CHUNK +: CHUNK];
            end
        end
        ch_sum = {1'b0, a_ch} + {1'b0, b_ch} + {{CHUNK{1'b0}}, carry};
        for (int i = 0; i < NCHUNK; i++) begin
            if (idx == IDXW'(i)) begin
                sum_nxt[i*CHUNK +: CHUNK] = ch_sum[CHUNK-1:0];
            end
        end
        last    = (idx == LAST);
        // On the last chunk the top bit of ch_sum's data part is the final sum MSB.
        ovf_nxt = (a_q[MSB] == b_q[MSB]) && (ch_sum[CHUNK-1] != a_q[MSB]);
    end

`ifdef SERIAL_ADDER_ZERO_FLAG_EN
    logic zacc;
    logic ch_zero;
    assign ch_zero = ~|ch_sum[CHUNK-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zacc <= 1'b0;
            zero <= 1'b0;
        end else if (state == IDLE && in_valid && in_ready) begin
            zacc <= 1'b1;
            zero <= 1'b0;
        end else if (state == RUN) begin
            zacc <= zacc & ch_zero;
            if (last) begin
                zero <= zacc & ch_zero;
            end
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            overflow  <= 1'b0;
            idx       <= '0;
            carry     <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_q      <= in0;
                        b_q      <= sub ? ~in1 : in1;
                        carry    <= sub | cin;
                        idx      <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    sum   <= sum_nxt;
                    carry <= ch_sum[CHUNK];
                    if (last) begin
                        cout      <= ch_sum[CHUNK];
                        overflow  <= ovf_nxt;
                        out_valid <= 1'b1;
                        idx       <= '0;
                        state     <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_nbit.sv
// Bench for serial_adder_nbit: three instances (CHUNK=4, 16, 1) checked against an arithmetic reference model.
module tb_serial_adder_nbit;

    localparam int W = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [2:0]   ivld;
    logic [2:0]   irdy;
    logic [2:0]   ovld;
    logic [2:0]   ordy;
    logic [2:0]   co;
    logic [2:0]   of;
    logic [2:0]   zr;
    logic [W-1:0] sm [3];
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         cin_in;
    logic         sub_in;

    int checks   = 0;
    int failures = 0;
    int lat_exp [3] = '{4, 1, 16};

    serial_adder_nbit #(.WIDTH(16), .CHUNK(4)) u_c4 (
        .clk(clk), .rst(rst), .in_valid(ivld[0]), .in_ready(irdy[0]),
        .in0(a_in), .in1(b_in), .cin(cin_in), .sub(sub_in),
        .out_valid(ovld[0]), .out_ready(ordy[0]), .sum(sm[0]), .cout(co[0]), .overflow(of[0])
`ifdef SERIAL_ADDER_ZERO_FLAG_EN
        , .zero(zr[0])
`endif
    );

    serial_adder_nbit #(.WIDTH(16), .CHUNK(16)) u_c16 (
        .clk(clk), .rst(rst), .in_valid(ivld[1]), .in_ready(irdy[1]),
        .in0(a_in), .in1(b_in), .cin(cin_in), .sub(sub_in),
        .out_valid(ovld[1]), .out_ready(ordy[1]), .sum(sm[1]), .cout(co[1]), .overflow(of[1])
`ifdef SERIAL_ADDER_ZERO_FLAG_EN
        , .zero(zr[1])
`endif
    );

    serial_adder_nbit #(.WIDTH(16), .CHUNK(1)) u_c1 (
        .clk(clk), .rst(rst), .in_valid(ivld[2]), .in_ready(irdy[2]),
        .in0(a_in), .in1(b_in), .cin(cin_in), .sub(sub_in),
        .out_valid(ovld[2]), .out_ready(ordy[2]), .sum(sm[2]), .cout(co[2]), .overflow(of[2])
`ifdef SERIAL_ADDER_ZERO_FLAG_EN
        , .zero(zr[2])
`endif
    );

`ifndef SERIAL_ADDER_ZERO_FLAG_EN
    assign zr = 3'b000;
`endif

    // Directed cases: a, b, cin, sub -> sum, cout, overflow
    logic [W-1:0] d_a   [8] = '{16'h1234, 16'hFFFF, 16'hFFFE, 16'h0005, 16'h0007, 16'h8000, 16'h7FFF, 16'h8000};
    logic [W-1:0] d_b   [8] = '{16'h4321, 16'h0001, 16'h0000, 16'h0007, 16'h0005, 16'h0001, 16'h0001, 16'h8000};
    logic         d_c   [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic         d_s   [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [W-1:0] d_sum [8] = '{16'h5555, 16'h0000, 16'hFFFF, 16'hFFFE, 16'h0002, 16'h7FFF, 16'h8000, 16'h0000};
    logic         d_co  [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic         d_ov  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    // Reference: returns {overflow, cout, sum} from plain integer arithmetic.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic c, input logic s);
        logic [W:0]   t;
        logic [W-1:0] r;
        logic         cy;
        int           sa, sb, sr;
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (s) begin
            r  = a - b;
            cy = (a >= b);
            sr = sa - sb;
        end else begin
            t  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
            r  = t[W-1:0];
            cy = t[W];
            sr = sa + sb + (c ? 1 : 0);
        end
        return {((sr > 32767) || (sr < -32768)), cy, r};
    endfunction

    // Drive one operation on instance u and collect the result; rdy_bad flags any handshake misbehaviour.
    task automatic do_op(input int u, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic c, input logic s,
                         output logic [W-1:0] rs, output logic rc, output logic ro, output logic rz,
                         output int lat, output logic rdy_bad);
        rdy_bad = 1'b0;
        lat     = 0;
        @(negedge clk);
        a_in = a; b_in = b; cin_in = c; sub_in = s;
        ivld[u] = 1'b1;
        @(posedge clk);
        #1;
        ivld[u] = 1'b0;
        a_in   = W'($urandom);
        b_in   = W'($urandom);
        cin_in = 1'($urandom);
        sub_in = 1'($urandom);
        if (irdy[u]) rdy_bad = 1'b1;
        while (!ovld[u] && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (irdy[u]) rdy_bad = 1'b1;
        end
        rs = sm[u]; rc = co[u]; ro = of[u]; rz = zr[u];
        ordy[u] = 1'b1;
        @(posedge clk);
        #1;
        ordy[u] = 1'b0;
        if (ovld[u] || !irdy[u]) rdy_bad = 1'b1;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (irdy !== 3'b111) begin failures++; $display("FAIL reset_in_ready got=%b exp=111", irdy); end
        checks++;
        if (ovld !== 3'b000) begin failures++; $display("FAIL reset_out_valid got=%b exp=000", ovld); end
        checks++;
        if ({co, of, zr} !== 9'b0) begin failures++; $display("FAIL reset_flags got=%b exp=0", {co, of, zr}); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (sm[i] !== 16'h0) begin failures++; $display("FAIL reset_sum[%0d] got=%h exp=0000", i, sm[i]); end
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [W-1:0] rs;
        logic rc, ro, rz, bad;
        int lat;
        for (int i = 0; i < 8; i++) begin
            do_op(0, d_a[i], d_b[i], d_c[i], d_s[i], rs, rc, ro, rz, lat, bad);
            checks++;
            if (rs !== d_sum[i]) begin failures++; $display("FAIL dir_sum[%0d] got=%h exp=%h", i, rs, d_sum[i]); end
            checks++;
            if (rc !== d_co[i]) begin failures++; $display("FAIL dir_cout[%0d] got=%b exp=%b", i, rc, d_co[i]); end
            checks++;
            if (ro !== d_ov[i]) begin failures++; $display("FAIL dir_ovf[%0d] got=%b exp=%b", i, ro, d_ov[i]); end
            checks++;
            if (lat !== 4) begin failures++; $display("FAIL dir_latency[%0d] got=%0d exp=4", i, lat); end
            checks++;
            if (bad !== 1'b0) begin failures++; $display("FAIL dir_handshake[%0d] got=%b exp=0", i, bad); end
`ifdef SERIAL_ADDER_ZERO_FLAG_EN
            checks++;
            if (rz !== (d_sum[i] == 16'h0)) begin failures++; $display("FAIL dir_zero[%0d] got=%b exp=%b", i, rz, d_sum[i] == 16'h0); end
`endif
        end
    endtask

    task automatic test_chunk_widths();
        logic [W-1:0] rs;
        logic rc, ro, rz, bad;
        int lat;
        for (int u = 1; u < 3; u++) begin
            do_op(u, 16'h1234, 16'h4321, 1'b0, 1'b0, rs, rc, ro, rz, lat, bad);
            checks++;
            if (rs !== 16'h5555 || rc !== 1'b0 || ro !== 1'b0) begin
                failures++; $display("FAIL chunk_result[u%0d] got=%h/%b/%b exp=5555/0/0", u, rs, rc, ro);
            end
            checks++;
            if (lat !== lat_exp[u]) begin failures++; $display("FAIL chunk_latency[u%0d] got=%0d exp=%0d", u, lat, lat_exp[u]); end
            checks++;
            if (bad !== 1'b0) begin failures++; $display("FAIL chunk_handshake[u%0d] got=%b exp=0", u, bad); end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] rs, a, b;
        logic [W+1:0] exp;
        logic rc, ro, rz, bad, c, s;
        int lat, u;
        logic [W-1:0] edges [4] = '{16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF};
        for (int n = 0; n < 45; n++) begin
            u = int'($urandom_range(0, 2));
            a = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 3)] : W'($urandom);
            b = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 3)] : W'($urandom);
            c = 1'($urandom);
            s = 1'($urandom);
            exp = model(a, b, c, s);
            do_op(u, a, b, c, s, rs, rc, ro, rz, lat, bad);
            checks++;
            if ({ro, rc, rs} !== exp) begin
                failures++;
                $display("FAIL rand[%0d] u%0d a=%h b=%h c=%b s=%b got=%b/%b/%h exp=%b/%b/%h",
                         n, u, a, b, c, s, ro, rc, rs, exp[W+1], exp[W], exp[W-1:0]);
            end
            checks++;
            if (lat !== lat_exp[u] || bad !== 1'b0) begin
                failures++; $display("FAIL rand_timing[%0d] u%0d lat=%0d bad=%b exp lat=%0d bad=0", n, u, lat, bad, lat_exp[u]);
            end
`ifdef SERIAL_ADDER_ZERO_FLAG_EN
            checks++;
            if (rz !== (exp[W-1:0] == 16'h0)) begin failures++; $display("FAIL rand_zero[%0d] got=%b exp=%b", n, rz, exp[W-1:0] == 16'h0); end
`endif
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] rs;
        logic rc, ro, rz, bad;
        int lat, n;
        @(negedge clk);
        a_in = 16'h1111; b_in = 16'h2222; cin_in = 1'b0; sub_in = 1'b0;
        ivld[0] = 1'b1;
        @(posedge clk);
        #1;
        ivld[0] = 1'b0;
        @(negedge clk);
        a_in = 16'hAAAA; b_in = 16'h5555; sub_in = 1'b1;
        ivld[0] = 1'b1;
        @(negedge clk);
        ivld[0] = 1'b0;
        n = 0;
        while (!ovld[0] && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (ovld[0] !== 1'b1) begin failures++; $display("FAIL bp_done_timeout got=%b exp=1", ovld[0]); end
        ivld[0] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (sm[0] !== 16'h3333 || co[0] !== 1'b0 || of[0] !== 1'b0) begin
                failures++; $display("FAIL bp_hold[%0d] got=%h/%b/%b exp=3333/0/0", k, sm[0], co[0], of[0]);
            end
            checks++;
            if (ovld[0] !== 1'b1 || irdy[0] !== 1'b0) begin
                failures++; $display("FAIL bp_flags[%0d] got ov=%b ir=%b exp ov=1 ir=0", k, ovld[0], irdy[0]);
            end
        end
        ivld[0] = 1'b0;
        ordy[0] = 1'b1;
        @(posedge clk);
        #1;
        ordy[0] = 1'b0;
        checks++;
        if (ovld[0] !== 1'b0 || irdy[0] !== 1'b1 || sm[0] !== 16'h3333) begin
            failures++; $display("FAIL bp_release got ov=%b ir=%b sum=%h exp ov=0 ir=1 sum=3333", ovld[0], irdy[0], sm[0]);
        end
        do_op(0, 16'h0101, 16'h0202, 1'b0, 1'b0, rs, rc, ro, rz, lat, bad);
        checks++;
        if (rs !== 16'h0303 || lat !== 4 || bad !== 1'b0) begin
            failures++; $display("FAIL bp_next got sum=%h lat=%0d bad=%b exp sum=0303 lat=4 bad=0", rs, lat, bad);
        end
    endtask

    task automatic test_reset_midop();
        logic [W-1:0] rs;
        logic rc, ro, rz, bad;
        int lat;
        @(negedge clk);
        a_in = 16'hFFFF; b_in = 16'hFFFF; cin_in = 1'b1; sub_in = 1'b0;
        ivld[0] = 1'b1;
        @(posedge clk);
        #1;
        ivld[0] = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (irdy[0] !== 1'b1 || ovld[0] !== 1'b0) begin
            failures++; $display("FAIL midrst_flags got ir=%b ov=%b exp ir=1 ov=0", irdy[0], ovld[0]);
        end
        checks++;
        if (sm[0] !== 16'h0 || co[0] !== 1'b0 || of[0] !== 1'b0) begin
            failures++; $display("FAIL midrst_result got=%h/%b/%b exp=0000/0/0", sm[0], co[0], of[0]);
        end
        @(negedge clk);
        rst = 1'b0;
        do_op(0, 16'h0001, 16'h0001, 1'b0, 1'b0, rs, rc, ro, rz, lat, bad);
        checks++;
        if (rs !== 16'h0002 || rc !== 1'b0 || ro !== 1'b0) begin
            failures++; $display("FAIL midrst_next got=%h/%b/%b exp=0002/0/0", rs, rc, ro);
        end
        checks++;
        if (lat !== 4 || bad !== 1'b0) begin
            failures++; $display("FAIL midrst_timing got lat=%0d bad=%b exp lat=4 bad=0", lat, bad);
        end
    endtask

    initial begin
        rst = 1'b1;
        ivld = 3'b000;
        ordy = 3'b000;
        a_in = '0; b_in = '0; cin_in = 1'b0; sub_in = 1'b0;
        test_reset();
        test_directed();
        test_chunk_widths();
        test_backpressure();
        test_reset_midop();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
